// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared ALU op codes and divider state encoding for the HI/LO unit
package hilo_muldiv_pkg;
  localparam logic [4:0] ALU_MTHI  = 5'h11;
  localparam logic [4:0] ALU_MTLO  = 5'h13;
  localparam logic [4:0] ALU_MULT  = 5'h18;
  localparam logic [4:0] ALU_MULTU = 5'h19;
  localparam logic [4:0] ALU_DIV   = 5'h1a;
  localparam logic [4:0] ALU_DIVU  = 5'h1b;
  typedef enum logic {IDLE, DIV_RUN} div_state_t;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// div_radix2: iterative restoring divider, one quotient bit per cycle with sign fixups
module div_radix2
  import hilo_muldiv_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_i,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  localparam int CNT_W = $clog2(DIV_ITER);
  div_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] pr_q, qd_q, bm_q, q_next, r_next;
  logic [32:0] sh;
  logic nq_q, nr_q, qbit, last;
  // one restoring step on magnitudes, final sign fixups, and next state
  always_comb begin
    sh = {pr_q, qd_q[31]};
    qbit = sh >= {1'b0, bm_q};
    q_next = {qd_q[30:0], qbit};
    r_next = qbit ? 32'(sh - {1'b0, bm_q}) : sh[31:0];
    last = cnt_q == CNT_W'(DIV_ITER - 1);
    busy = state_q == DIV_RUN;
    done = busy && last;
    quot = nq_q ? -q_next : q_next;
    rem = nr_q ? -r_next : r_next;
    state_d = state_q == IDLE ? (start ? DIV_RUN : IDLE) : (abort || last ? IDLE : DIV_RUN);
  end
  // state, counter, partial remainder and operand latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pr_q <= '0;
      qd_q <= '0;
      bm_q <= '0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
        pr_q <= '0;
        qd_q <= mag(a, signed_i && a[31]);
        bm_q <= mag(b, signed_i && b[31]);
        nq_q <= signed_i && (a[31] ^ b[31]);
        nr_q <= signed_i && a[31];
      end else if (busy) begin
        cnt_q <= cnt_q + 1'b1;
        pr_q <= r_next;
        qd_q <= q_next;
      end
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with single-cycle multiply/move and iterative divide
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  logic is_div, issue, start, busy, div_done, commit, done_q;
  logic [31:0] quot, rem;
  logic [63:0] prod;
  div_radix2 #(.DIV_ITER(DIV_ITER)) u_div (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(flush_i),
    .signed_i(op_i == ALU_DIV),
    .a(a_i),
    .b(b_i),
    .busy(busy),
    .done(div_done),
    .quot(quot),
    .rem(rem)
  );
  // issue qualification, stall, and the 64-bit product (sign-extended operands give the signed product)
  always_comb begin
    is_div = op_i == ALU_DIV || op_i == ALU_DIVU;
    issue = valid_i && !busy && !flush_i;
    start = issue && is_div && !done_q;
    commit = div_done && !flush_i;
    stall_o = start || (busy && !(div_done && flush_i));
    prod = op_i == ALU_MULT ? {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i} : {32'b0, a_i} * {32'b0, b_i};
  end
  // HI/LO commits; done flag blocks the re-presented divide for one cycle after completion
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) {hi_o, lo_o} <= {rem, quot};
      else if (issue && (op_i == ALU_MULT || op_i == ALU_MULTU)) {hi_o, lo_o} <= prod;
      else if (issue && op_i == ALU_MTHI) hi_o <= a_i;
      else if (issue && op_i == ALU_MTLO) lo_o <= a_i;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst, valid, flush, stall;
  logic [4:0] op;
  logic [31:0] a, b, hi, lo;
  logic [31:0] hi_m = '0, lo_m = '0;
  int total = 0, bad = 0;
  typedef struct {logic [4:0] o; logic [31:0] a, b, h, l; int st;} vec_t;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .valid_i(valid), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .stall_o(stall), .hi_o(hi), .lo_o(lo)
  );

  // reference: architectural result of one instruction and its expected stall length
  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, output int st);
    logic [31:0] ma, mb, q, r;
    logic sg;
    longint p;
    st = 0;
    if (o == ALU_MULT) begin
      p = longint'($signed(x)) * longint'($signed(y));
      {hi_m, lo_m} = p;
    end else if (o == ALU_MULTU) begin
      {hi_m, lo_m} = {32'b0, x} * {32'b0, y};
    end else if (o == ALU_MTHI) begin
      hi_m = x;
    end else if (o == ALU_MTLO) begin
      lo_m = x;
    end else if (o == ALU_DIV || o == ALU_DIVU) begin
      st = 33;
      sg = o == ALU_DIV;
      ma = (sg && x[31]) ? -x : x;
      mb = (sg && y[31]) ? -y : y;
      q = mb == 0 ? 32'hFFFFFFFF : ma / mb;
      r = mb == 0 ? ma : ma % mb;
      if (sg && (x[31] ^ y[31])) q = -q;
      if (sg && x[31]) r = -r;
      hi_m = r;
      lo_m = q;
    end
  endtask

  // present an instruction, hold it while stalled plus one cycle, count stall cycles
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit keep, output int n);
    valid = 1'b1; op = o; a = x; b = y; n = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    @(negedge clk);
    if (!keep) begin valid = 1'b0; op = 5'h00; end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 5'h00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    total += 3;
    if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    vec_t v[7] = '{
      '{ALU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0},
      '{ALU_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 0},
      '{ALU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33},
      '{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33},
      '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33},
      '{ALU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33},
      '{ALU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001, 33}};
    int n, st;
    foreach (v[i]) begin
      model(v[i].o, v[i].a, v[i].b, st);
      run_op(v[i].o, v[i].a, v[i].b, 1'b0, n);
      total += 3;
      if (n !== v[i].st) begin bad++; $display("FAIL dir%0d_stall got=%0d want=%0d", i, n, v[i].st); end
      if (hi !== v[i].h) begin bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, v[i].h); end
      if (lo !== v[i].l) begin bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, v[i].l); end
    end
  endtask

  task automatic test_mult_move;
    logic [4:0] ops[5] = '{ALU_MULT, ALU_MULTU, ALU_MTHI, ALU_MTLO, 5'h00};
    logic [4:0] o;
    logic [31:0] x, y;
    int n, st;
    for (int i = 0; i < 20; i++) begin
      o = ops[$urandom_range(0, 4)];
      x = $urandom;
      y = $urandom;
      model(o, x, y, st);
      run_op(o, x, y, 1'b0, n);
      total += 3;
      if (n !== st) begin bad++; $display("FAIL mul%0d_stall op=%h got=%0d want=%0d", i, o, n, st); end
      if (hi !== hi_m) begin bad++; $display("FAIL mul%0d_hi op=%h got=%h want=%h", i, o, hi, hi_m); end
      if (lo !== lo_m) begin bad++; $display("FAIL mul%0d_lo op=%h got=%h want=%h", i, o, lo, lo_m); end
    end
  endtask

  task automatic test_div_random;
    logic [4:0] o;
    logic [31:0] x, y;
    int n, st;
    for (int i = 0; i < 8; i++) begin
      o = $urandom_range(0, 1) ? ALU_DIV : ALU_DIVU;
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'h0;
        1: y = $urandom_range(1, 300);
        2: y = -$urandom_range(1, 300);
        default: y = $urandom;
      endcase
      model(o, x, y, st);
      run_op(o, x, y, 1'b0, n);
      total += 3;
      if (n !== st) begin bad++; $display("FAIL div%0d_stall got=%0d want=%0d", i, n, st); end
      if (hi !== hi_m) begin bad++; $display("FAIL div%0d_hi a=%h b=%h got=%h want=%h", i, x, y, hi, hi_m); end
      if (lo !== lo_m) begin bad++; $display("FAIL div%0d_lo a=%h b=%h got=%h want=%h", i, x, y, lo, lo_m); end
    end
  endtask

  task automatic test_back_to_back;
    int n, st;
    model(ALU_DIVU, 32'd9, 32'd3, st);
    run_op(ALU_DIVU, 32'd9, 32'd3, 1'b1, n);
    total += 3;
    if (n !== 33) begin bad++; $display("FAIL b2b_first_stall got=%0d want=33", n); end
    if (hi !== 32'd0) begin bad++; $display("FAIL b2b_first_hi got=%h want=0", hi); end
    if (lo !== 32'd3) begin bad++; $display("FAIL b2b_first_lo got=%h want=3", lo); end
    model(ALU_DIV, 32'hFFFFFF9C, 32'd7, st);
    run_op(ALU_DIV, 32'hFFFFFF9C, 32'd7, 1'b1, n);
    total += 3;
    if (n !== st) begin bad++; $display("FAIL b2b_second_stall got=%0d want=%0d", n, st); end
    if (hi !== hi_m) begin bad++; $display("FAIL b2b_second_hi got=%h want=%h", hi, hi_m); end
    if (lo !== lo_m) begin bad++; $display("FAIL b2b_second_lo got=%h want=%h", lo, lo_m); end
    model(ALU_MULT, 32'd6, 32'hFFFFFFFE, st);
    run_op(ALU_MULT, 32'd6, 32'hFFFFFFFE, 1'b0, n);
    total += 3;
    if (n !== 0) begin bad++; $display("FAIL b2b_mult_stall got=%0d want=0", n); end
    if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_mult_hi got=%h want=ffffffff", hi); end
    if (lo !== 32'hFFFFFFF4) begin bad++; $display("FAIL b2b_mult_lo got=%h want=fffffff4", lo); end
  endtask

  task automatic test_flush;
    int n, st;
    model(ALU_MTHI, 32'h11, 32'h0, st);
    run_op(ALU_MTHI, 32'h11, 32'h0, 1'b0, n);
    model(ALU_MTLO, 32'h22, 32'h0, st);
    run_op(ALU_MTLO, 32'h22, 32'h0, 1'b0, n);
    valid = 1'b1; op = ALU_DIVU; a = 32'd100; b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; valid = 1'b0;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL flush_c10_stall got=%b want=1", stall); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total += 3;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_c11_stall got=%b want=0", stall); end
    if (hi !== 32'h11) begin bad++; $display("FAIL flush_hi got=%h want=11", hi); end
    if (lo !== 32'h22) begin bad++; $display("FAIL flush_lo got=%h want=22", lo); end
    repeat (40) @(negedge clk);
    #1;
    total += 2;
    if (hi !== 32'h11) begin bad++; $display("FAIL flush_late_hi got=%h want=11", hi); end
    if (lo !== 32'h22) begin bad++; $display("FAIL flush_late_lo got=%h want=22", lo); end
    flush = 1'b1;
    run_op(ALU_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, n);
    run_op(ALU_DIVU, 32'd50, 32'd3, 1'b0, n);
    flush = 1'b0;
    total += 3;
    if (n !== 0) begin bad++; $display("FAIL idle_flush_stall got=%0d want=0", n); end
    if (hi !== 32'h11) begin bad++; $display("FAIL idle_flush_hi got=%h want=11", hi); end
    if (lo !== 32'h22) begin bad++; $display("FAIL idle_flush_lo got=%h want=22", lo); end
  endtask

  task automatic test_reset_mid_div;
    int n, st;
    model(ALU_MTHI, 32'h11, 32'h0, st);
    run_op(ALU_MTHI, 32'h11, 32'h0, 1'b0, n);
    model(ALU_MTLO, 32'h22, 32'h0, st);
    run_op(ALU_MTLO, 32'h22, 32'h0, 1'b0, n);
    valid = 1'b1; op = ALU_DIVU; a = 32'd100; b = 32'd7;
    repeat (10) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    #1;
    total += 3;
    if (stall !== 1'b0) begin bad++; $display("FAIL rstdiv_stall got=%b want=0", stall); end
    if (hi !== 32'h0) begin bad++; $display("FAIL rstdiv_hi got=%h want=0", hi); end
    if (lo !== 32'h0) begin bad++; $display("FAIL rstdiv_lo got=%h want=0", lo); end
    repeat (40) @(negedge clk);
    #1;
    total += 2;
    if (hi !== 32'h0) begin bad++; $display("FAIL rstdiv_late_hi got=%h want=0", hi); end
    if (lo !== 32'h0) begin bad++; $display("FAIL rstdiv_late_lo got=%h want=0", lo); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mult_move;
    test_div_random;
    test_back_to_back;
    test_flush;
    test_reset_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide unit and HI/LO register pair for the MIPS pipeline. It receives MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the execute stage and commits their results to HI/LO. It serves HI/LO values to the execute stage for MFHI/MFLO. Multiplies and moves commit in one cycle. Divides run iteratively over 32 cycles and stall the pipeline through `stall_o`.

## Interface
- `DIV_ITER`, 32: divider iterations, one quotient bit per cycle; fixed at 32 for this ISA.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: execute-stage instruction valid and not stalled by an earlier stage.
- `op_i` in 5: ALU op code, shared ALU define encoding. Acts only on `ALU_MULT`, `ALU_MULTU`, `ALU_DIV`, `ALU_DIVU`, `ALU_MTHI` and `ALU_MTLO`; all other codes are no-ops.
- `a_i` in 32: rs operand (dividend, multiplicand, or MTHI/MTLO data).
- `b_i` in 32: rt operand (divisor, multiplier).
- `flush_i` in 1: exception/flush from the pipeline; aborts any in-flight divide.
- `stall_o` out 1: hold execute stage and everything upstream.
- `hi_o` out 32: current HI register value.
- `lo_o` out 32: current LO register value.

## Operation
- **Reset:** HI=0, LO=0, state IDLE, iteration counter 0, `stall_o`=0. Reset overrides every other input, including an in-flight divide.
- **States:** IDLE and DIV_RUN.
- **IDLE, `valid_i` && MULT:**
  - {HI,LO} <= signed 64-bit product of `a_i` and `b_i` at the next edge.
  - MULTU uses the unsigned product.
  - No stall.
- **IDLE, `valid_i` && MTHI/MTLO:** HI (or LO) <= `a_i` at the next edge; the other register is unchanged.
- **IDLE, `valid_i` && DIV/DIVU:**
  - Latch the magnitudes of the operands, the sign of the dividend, and sign(a) XOR sign(b). DIVU treats both signs as 0.
  - Clear the counter and go to DIV_RUN.
- **DIV_RUN:**
  - Restoring radix-2 division on magnitudes, with a 33-bit partial remainder.
  - One quotient bit per cycle, MSB first; the counter increments each cycle.
  - On the cycle where the counter reaches DIV_ITER-1, apply the sign fixups, write LO=quotient and HI=remainder, and return to IDLE.
- **Sign rules:**
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- **Divide by zero:** no trap. The algorithm yields magnitude quotient 0xFFFFFFFF and remainder = |a|, then the sign rules apply. The bench checks exactly this value.
- **`flush_i` in DIV_RUN:** return to IDLE next edge; HI/LO unchanged.
- **`flush_i` in IDLE:** suppresses any commit in the same cycle.
- **`valid_i` while in DIV_RUN:** ignored. Upstream is held by `stall_o`, so the same instruction is re-presented; the unit does not restart it.
- **Re-presented divide:** the divide instruction stays in execute during DIV_RUN. A one-bit "done" flag set on completion prevents it from re-issuing in the following IDLE cycle. The flag clears when `valid_i` drops or when the stall releases and the pipeline advances (next cycle).

## Timing
- **`stall_o` (combinational):**
  - 1 when (IDLE && `valid_i` && DIV/DIVU && !done && !`flush_i`).
  - 1 when in DIV_RUN and not on the final iteration.
  - 1 when in DIV_RUN and `flush_i` is low.
- **Divide latency:**
  - Issue at cycle 0; `stall_o` is high on cycles 0..32 (33 cycles).
  - New HI/LO are visible on `hi_o`/`lo_o` from cycle 33.
- **MULT/MTHI/MTLO latency:** result visible one cycle after issue.
- **Reads:** `hi_o`/`lo_o` are register outputs with no internal bypass. Forwarding from a same-cycle write belongs to the pipeline hazard unit.

## Structure
- **Shared header:** op codes come from the existing ALU defines header; no new encodings.
- **Local parameter:** state encoding.
- **Sub-module `div_radix2`:**
  - Ports: `clk`, `rst`, `start`, `abort`, `signed_i`, `a`, `b`, `busy`, `done`, `quot`, `rem`.
  - Holds the counter, the partial remainder, and the sign fixups.
- **Top level:** multiply, HI/LO registers, done flag, and stall logic.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 one cycle later; `stall_o` never high. MULTU of the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100/7 -> `stall_o` high exactly 33 cycles; then LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV -5/0 -> LO=0x00000001, HI=0xFFFFFFFB.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO. Start DIVU, assert `flush_i` at cycle 10 -> `stall_o` low at cycle 11; HI/LO stay 0x11/0x22. Repeat with `rst` at cycle 10 -> HI=LO=0.
- Hold `valid_i` with DIVU 9/3 for the full stall and one cycle after -> exactly one commit (LO=3, HI=0), no second 33-cycle stall.
